// File: rtl/fifo_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_param_if : handshake/data bundle between a producer/consumer and fifo_param
// Rev 1.0
// ---------------------------------------------------------------------------
interface fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               en;
  logic               wr;
  logic               rd;
  logic [DATA_W-1:0]  data_in;
  logic [DATA_W-1:0]  data_out;
  logic               empty;
  logic               full;
  logic               almost_full;
  logic               almost_empty;
  logic [c_cnt_w-1:0] count;
  logic               overflow;
  logic               underflow;

  modport master (
    output en, wr, rd, data_in,
    input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  en, wr, rd, data_in,
    output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_param : parametrised single-clock FIFO with count, almost flags, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output.      Rev 1.0
// ---------------------------------------------------------------------------
module fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  fifo_param_if.slave bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_LEVEL);
  localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_LEVEL);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_pinc  = c_ptr_w'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("fifo_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_empty;
  logic               r_full;
  logic               r_almost_full;
  logic               r_almost_empty;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_rd_rej;
  logic               w_wr_rej;
  logic [c_ptr_w-1:0] w_wr_ptr_next;
  logic [c_ptr_w-1:0] w_rd_ptr_next;
  logic [c_cnt_w-1:0] w_count_next;

  // A read on a full FIFO frees the slot the simultaneous write reuses.
  always_comb begin
    w_rd_acc      = bus.en & bus.rd & ~r_empty;
    w_wr_acc      = bus.en & bus.wr & (~r_full | w_rd_acc);
    w_rd_rej      = bus.en & bus.rd & r_empty;
    w_wr_rej      = bus.en & bus.wr & ~w_wr_acc;
    w_wr_ptr_next = w_wr_acc ? r_wr_ptr + c_pinc : r_wr_ptr;
    w_rd_ptr_next = w_rd_acc ? r_rd_ptr + c_pinc : r_rd_ptr;
    w_count_next  = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + c_one;
      2'b01:   w_count_next = r_count - c_one;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_next;
      r_rd_ptr       <= w_rd_ptr_next;
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == c_depth);
      r_almost_full  <= (w_count_next >= c_af);
      r_almost_empty <= (w_count_next <= c_ae);
      r_overflow     <= r_overflow | w_wr_rej;
      r_underflow    <= r_underflow | w_rd_rej;
    end
  end

`ifdef FIFO_FWFT_EN
  // The new head may be the word written on this very edge (count 0->1 or 1->1).
  logic w_head_is_new;
  assign w_head_is_new = w_wr_acc && (r_wr_ptr == w_rd_ptr_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if ((w_rd_acc || w_wr_acc) && w_count_next != '0) begin
      r_data_out <= w_head_is_new ? bus.data_in : r_mem[w_rd_ptr_next];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end
`endif

  assign bus.data_out     = r_data_out;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// tb_fifo_param : randomized, model-checked bench for fifo_param (both output modes).
module tb_fifo_param;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;
  localparam int VW     = DATA_W + 4 + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of stored words plus sticky flags and output word.
  logic [DATA_W-1:0] q[$];
  logic              m_ovf;
  logic              m_unf;
  logic [DATA_W-1:0] m_dout;

  function automatic logic [VW-1:0] exp_vec();
    int n = q.size();
    return {m_dout, 4'(n), (n == 0), (n == DEPTH), (n >= AF), (n <= AE), m_ovf, m_unf};
  endfunction

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.data_out, bus.count, bus.empty, bus.full, bus.almost_full,
                    bus.almost_empty, bus.overflow, bus.underflow};

  function automatic void model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endfunction

  function automatic void model_step(input bit e, input bit w, input bit r, input logic [DATA_W-1:0] d);
    bit ra, wa;
    logic [DATA_W-1:0] popped;
    if (!e) return;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < DEPTH) || ra);
    if (r && !ra) m_unf = 1'b1;
    if (w && !wa) m_ovf = 1'b1;
    if (ra) begin
      popped = q.pop_front();
`ifndef FIFO_FWFT_EN
      m_dout = popped;
`endif
    end
    if (wa) q.push_back(d);
`ifdef FIFO_FWFT_EN
    if ((ra || wa) && q.size() > 0) m_dout = q[0];
`endif
  endfunction

  task automatic step(input bit e, input bit w, input bit r, input logic [DATA_W-1:0] d);
    bus.en = e; bus.wr = w; bus.rd = r; bus.data_in = d;
    @(posedge clk);
    model_step(e, w, r, d);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.en = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = '0;
    rst = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (dut_vec !== {{DATA_W{1'b0}}, 4'd0, 6'b100100}) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, {{DATA_W{1'b0}}, 4'd0, 6'b100100});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, DATA_W'(i));
      n_checks++;
      if (dut_vec !== exp_vec() || bus.count !== 4'(i + 1)) begin
        n_errors++;
        $display("FAIL fill[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, 1'b0, 32'hDEAD);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL overflow: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.empty !== 1'b1 || bus.data_out !== 32'h7) begin
      n_errors++;
      $display("FAIL drain_end: got unf=%b empty=%b dout=%h expected unf=1 empty=1 dout=7",
               bus.underflow, bus.empty, bus.data_out);
    end
  endtask

  task automatic test_simultaneous_wrap();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h100 + DATA_W'(i));
      n_checks++;
      if (dut_vec !== exp_vec() || bus.count !== 4'd3 || bus.overflow || bus.underflow) begin
        n_errors++;
        $display("FAIL simul_wrap[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_boundary();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    n_checks++;
    if (dut_vec !== exp_vec() || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL full_rw: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    n_checks++;
    if (dut_vec !== exp_vec() || bus.count !== 4'd1 || bus.underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_rw: got %h expected %h", dut_vec, exp_vec());
    end
    step(1'b1, 1'b0, 1'b1, '0);
    n_checks++;
    if (dut_vec !== exp_vec() || bus.data_out !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL empty_rw_read: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_en_and_async_reset();
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'h11);
    step(1'b1, 1'b1, 1'b0, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h33);
      n_checks++;
      if (dut_vec !== exp_vec() || bus.count !== 4'd2) begin
        n_errors++;
        $display("FAIL en_gate[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h44);
    step(1'b1, 1'b1, 1'b1, 32'h55);
    // Reset asserted between edges; outputs must clear before the next rising edge.
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== {{DATA_W{1'b0}}, 4'd0, 6'b100100}) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected %h", dut_vec, {{DATA_W{1'b0}}, 4'd0, 6'b100100});
    end
    #1 rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL post_reset: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fwft();
`ifdef FIFO_FWFT_EN
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 32'hA5);
    step(1'b1, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.data_out !== 32'hA5 || bus.empty !== 1'b0 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL fwft_head: got dout=%h empty=%b expected dout=a5 empty=0", bus.data_out, bus.empty);
    end
`endif
  endtask

  task automatic test_random();
    bit e, w, r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      step(e, w, r, $urandom);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous_wrap();
    test_boundary();
    test_en_and_async_reset();
    test_fwft();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO, successor to the fixed 32-bit FIFO.
- Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags and a compile-time first-word-fall-through mode.
- Buffers data between a producer and a consumer in the same clock domain.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous reset, active-high.
- EN  in  1  global enable; when 0, RD and WR are ignored and all state holds.
- WR  in  1  write request.
- RD  in  1  read request.
- dataIn  in  DATA_W  write data, sampled on an accepted write.
- dataOut  out  DATA_W  read data.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == DEPTH.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky: a write was rejected.
- UNDERFLOW  out  1  sticky: a read was rejected.

Behaviour:
- Reset (Rst=1, asynchronous) values:
  - Pointers = 0, COUNT = 0, dataOut = 0.
  - EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
  - OVERFLOW = 0, UNDERFLOW = 0.
  - Storage array contents are not reset.
- Storage: DEPTH x DATA_W register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - COUNT is tracked separately, not derived from the pointers.
- Acceptance: all actions occur on a rising Clk edge with EN=1.
  - wr_acc = WR & (~FULL | RD_acc).
  - rd_acc = RD & ~EMPTY.
- Simultaneous RD and WR:
  - Not full, not empty: both are accepted and COUNT is unchanged.
  - Full: the read frees the slot, the write is accepted, COUNT stays DEPTH.
  - Empty: the write is accepted, the read is rejected, UNDERFLOW is set, COUNT becomes 1. There is no bypass of the array.
- Rejected operations:
  - WR while FULL without an accepted read: data is dropped, OVERFLOW is set, the pointer is unchanged.
  - RD while EMPTY: UNDERFLOW is set, dataOut holds.
- Sticky flags clear only on Rst.
- Default read latency (standard mode):
  - On rd_acc, dataOut is loaded with mem[rd_ptr] at that edge, so it is valid one cycle after RD is sampled.
  - dataOut otherwise holds its last value.
- Flag timing: all flags and COUNT are registered and reflect state after the edge. There are no combinational paths from RD or WR to any output.
- EN=0: no pointer, COUNT, flag or dataOut change. Rst still acts.
- Rst asserted mid-burst: in-flight data is discarded and the block returns to its reset values immediately, regardless of Clk.
- Elaboration checks: DEPTH must be a power of two, and AE_LEVEL < AF_LEVEL <= DEPTH. A violation raises an elaboration error.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dataOut presents the head entry mem[rd_ptr] whenever EMPTY=0, with no RD needed.
  - RD acknowledges and pops the word; the next head appears on dataOut in the cycle after the pop.
  - The first write into an empty FIFO appears on dataOut one cycle after the write edge, when EMPTY deasserts.
  - When EMPTY=1, dataOut holds its last value.
- Undefined: standard mode with registered read latency as described in Behaviour.

Test Plan:
- Reset and fill:
  - Stimulus: DATA_W=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2; Rst=1 for 5 cycles, then EN=1 and write 0x0..0x7.
  - Response: COUNT steps 1..8, ALMOST_EMPTY drops when COUNT=3, ALMOST_FULL rises when COUNT=6, FULL=1 after the 8th write, OVERFLOW=0.
- Overflow:
  - Stimulus: with the FIFO full, write 0xDEAD.
  - Response: OVERFLOW=1, COUNT=8; a subsequent drain returns 0x0..0x7 in order with no 0xDEAD.
- Drain and underflow:
  - Stimulus: RD for 9 cycles from full.
  - Response: dataOut = 0x0..0x7, each one cycle after its RD; EMPTY=1 after the 8th; the 9th read sets UNDERFLOW=1 and dataOut holds 0x7.
- Simultaneous RD and WR with wrap:
  - Stimulus: prefill 3 words, then hold RD=WR=1 for 12 cycles with incrementing data.
  - Response: COUNT stays 3, output order is preserved across pointer wrap, no error flags.
- Boundary simultaneity:
  - Stimulus: full plus RD=WR=1, and separately empty plus RD=WR=1.
  - Response: full case gives COUNT=8 and the write is stored; empty case gives COUNT=1 and UNDERFLOW=1.
- EN gating and asynchronous reset:
  - Stimulus: EN=0 with WR=1 for 4 cycles, then Rst pulsed between clock edges mid-fill.
  - Response: COUNT is unchanged while EN=0; on Rst all outputs return to reset values before the next Clk edge.
  - With FIFO_FWFT_EN defined: after writing 0xA5 into an empty FIFO, dataOut=0xA5 with RD=0.
